adc_serial_to_fixed: RTL and testbench

//   Input-side counterpart of the filter's output truncation stage. Drives a
//   16-clock serial ADC frame (AD7476-style: 4 leading zeros, then 12 data bits
//   MSB first). Converts the offset-binary sample into the filter's 29-bit

---
 rtl/adc_serial_to_fixed.sv | 131 +++++++++++++
 tb/tb_adc_serial_to_fixed.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_to_fixed.sv
// adc_serial_to_fixed
//   Runs one 16-clock serial ADC frame (4 leading zeros, then 12 data bits,
//   MSB first) per start request. The offset-binary code is turned into the
//   filter's signed Q10.18 input word. The sample lands in bits [17:7] with its
//   MSB inverted, which is the inverse of the filter's output truncation.
// Ports
//   clk, reset   system clock; synchronous active-high reset
//   start        sample request strobe, accepted only in IDLE
//   sdata        ADC serial data in
//   cs_n, sclk   ADC chip select (active low) and serial clock (idles high)
//   busy         frame or post-frame quiet time in progress
//   valid        one-cycle pulse when codigo/dato_filtro/frame_err update
//   frame_err    a leading bit of the last frame read 1
//   codigo       raw 12-bit ADC code of the last frame
//   dato_filtro  converted sample, signed Q10.18 (29 bits)
module adc_serial_to_fixed #(
  parameter int HALF_DIV   = 2,
  parameter int QUIET_CYC  = 4,
  parameter int LEAD_ZEROS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sdata,
  output logic        cs_n,
  output logic        sclk,
  output logic        busy,
  output logic        valid,
  output logic        frame_err,
  output logic [11:0] codigo,
  output logic [28:0] dato_filtro
);

  localparam int CMAX = (HALF_DIV > QUIET_CYC) ? HALF_DIV : QUIET_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          phase;     // 0: sclk low half, 1: sclk high half
  logic [3:0]    bit_cnt;
  logic [15:0]   sr;

  logic          half_end, quiet_end;
  logic [10:0]   c11, s;
  logic [28:0]   dato_c;

  assign half_end  = (cnt == CW'(HALF_DIV - 1));
  assign quiet_end = (cnt == CW'(QUIET_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state. SHIFT ends on the 16th rising sclk edge; the final high
  // half-period of sclk is spent in HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = SETUP;
      SETUP:   if (half_end)  state_nxt = SHIFT;
      SHIFT:   if (half_end && !phase && bit_cnt == 4'd15) state_nxt = HOLD;
      HOLD:    if (half_end)  state_nxt = QUIET;
      QUIET:   if (quiet_end) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cs_n = 1'b1;
    sclk = 1'b1;
    busy = (state != IDLE);
    case (state)
      SETUP, HOLD: cs_n = 1'b0;
      SHIFT: begin
        cs_n = 1'b0;
        sclk = phase;
      end
      default: ;
    endcase
  end

  // Conversion: drop the LSB (plain truncation), flip the MSB to go from
  // offset binary to two's complement, then place at bits [17:7].
  assign c11    = sr[11:1];
  assign s      = {~c11[10], c11[9:0]};
  assign dato_c = {{11{s[10]}}, s, 7'b0};

  // Timing counters, shift register and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      phase       <= 1'b0;
      bit_cnt     <= '0;
      sr          <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      codigo      <= '0;
      dato_filtro <= '0;
    end else begin
      valid <= 1'b0;

      // cnt restarts on every state change and every sclk half-period
      if (state == IDLE || state != state_nxt || (state == SHIFT && half_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != SHIFT) begin
        phase   <= 1'b0;
        bit_cnt <= '0;
      end else if (half_end) begin
        phase <= ~phase;
        if (!phase) sr      <= {sr[14:0], sdata};  // edge where sclk rises
        else        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == HOLD && half_end) begin
        valid       <= 1'b1;
        codigo      <= sr[11:0];
        frame_err   <= |sr[15:16-LEAD_ZEROS];
        dato_filtro <= dato_c;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_to_fixed.sv
module tb_adc_serial_to_fixed;

  localparam int HD = 2;
  localparam int QC = 4;
  localparam int LAT = 1 + 33 * HD;

  logic        clk = 1'b0;
  logic        reset, start, sdata;
  logic        cs_n, sclk, busy, valid, frame_err;
  logic [11:0] codigo;
  logic [28:0] dato_filtro;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] adc_word = 16'h0;
  int          bitn = 0;

  adc_serial_to_fixed #(.HALF_DIV(HD), .QUIET_CYC(QC), .LEAD_ZEROS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sdata(sdata),
    .cs_n(cs_n), .sclk(sclk), .busy(busy), .valid(valid),
    .frame_err(frame_err), .codigo(codigo), .dato_filtro(dato_filtro)
  );

  always #5 clk = ~clk;

  // ADC model: next bit appears on each falling sclk edge while selected
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n === 1'b1) bitn = 0;
    else if (cs_n === 1'b0 && bitn < 16) begin
      sdata = adc_word[15-bitn];
      bitn++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: value = (code/2 - 1024) / 2048 in Q10.18, i.e. (code/2 - 1024) * 128 LSBs
  function automatic logic [28:0] ref_dato(input logic [15:0] w);
    int v;
    v = ((int'(w[11:0]) >> 1) - 1024) * 128;
    return v[28:0];
  endfunction

  task automatic run_frame(input logic [15:0] w, input bit chk_lat);
    int n, k;
    adc_word = w;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    while (!valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 32'(valid), 32'd1);
    if (chk_lat) chk("latency", n, LAT);
    chk("codigo", 32'(codigo), 32'(w[11:0]));
    chk("dato", 32'(dato_filtro), 32'(ref_dato(w)));
    chk("frame_err", 32'(frame_err), 32'(w[15:12] != 4'h0));
    // Round trip back to the code with its LSB dropped
    chk("round_trip", 32'({~dato_filtro[17], dato_filtro[16:7]}), 32'(w[11:0] >> 1));
    chk("cs_n_hi", 32'(cs_n), 32'd1);
    @(negedge clk);
    chk("valid_1cyc", 32'(valid), 32'd0);
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    int nv, falls, valids, rise_t, t;
    bit have_rise;
    logic prev_cs;
    logic [15:0] w;

    reset = 1'b1; start = 1'b0; sdata = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_codigo", 32'(codigo), 32'd0);
    chk("rst_dato", 32'(dato_filtro), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: reset in the middle of SHIFT
    adc_word = 16'h0ABC;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    chk("t1_in_frame", 32'(cs_n), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_cs_n", 32'(cs_n), 32'd1);
    chk("t1_sclk", 32'(sclk), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_valid", 32'(valid), 32'd0);
    reset = 1'b0;
    nv = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("t1_no_valid", nv, 0);
    run_frame(16'h0123, 1'b1);

    // T2..T4 directed frames
    run_frame(16'h0FFF, 1'b1);
    chk("t2_dato_const", 32'(dato_filtro), 32'h0001FF80);
    run_frame(16'h0000, 1'b1);
    chk("t3_0000", 32'(dato_filtro), 32'h1FFE0000);
    run_frame(16'h0800, 1'b0);
    chk("t3_0800", 32'(dato_filtro), 32'h0);
    run_frame(16'h0801, 1'b0);
    chk("t3_0801", 32'(dato_filtro), 32'h0);
    run_frame(16'h8ABC, 1'b1);
    chk("t4_ferr", 32'(frame_err), 32'd1);

    // T5: start held high, frames back to back
    adc_word = 16'h0555;
    falls = 0; valids = 0; have_rise = 0; rise_t = 0;
    prev_cs = cs_n;
    start = 1'b1;
    t = 0;
    while (valids < 3 && t < 400) begin
      @(negedge clk);
      t++;
      if (cs_n && !prev_cs) begin
        rise_t = t;
        have_rise = 1;
      end
      if (!cs_n && prev_cs) begin
        falls++;
        if (have_rise) chk("t5_gap", t - rise_t, QC + 1);
      end
      if (valid) begin
        valids++;
        chk("t5_codigo", 32'(codigo), 32'h555);
      end
      prev_cs = cs_n;
    end
    start = 1'b0;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      if (valid) valids++;
      t++;
    end
    chk("t5_valids", valids, 3);
    chk("t5_falls", falls, 3);

    // T6: random codes through the round trip, plus random lead bits
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom_range(0, 4095));
      if (i % 10 == 9) w[15:12] = 4'($urandom_range(1, 15));
      run_frame(w, 1'b0);
    end
    run_frame(16'h0001, 1'b0);
    run_frame(16'h07FF, 1'b0);
    run_frame(16'h0FFE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
